// File: rtl/mcu_ram_pkg.sv
// Shared types and defaults for the data-RAM access controller.
package mcu_ram_pkg;

  localparam int RAM_AW = 8;
  localparam int RAM_DW = 16;
  localparam int HOLD_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Preload value for the strobe-hold down-counter (counts HOLD_CYC-1 .. 0).
  function automatic logic [HOLD_W-1:0] hold_load(input int hold_cyc);
    return HOLD_W'(hold_cyc - 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant register lives in the parent.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       enable,
  output logic [1:0] gnt
);

  // A lone requester wins outright; on contention the port that did not go last wins.
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Two-port arbiter and strobe sequencer for the edge-strobed 256x16 data RAM.
module ram_access_ctrl
  import mcu_ram_pkg::*;
#(
  parameter int AW       = RAM_AW,
  parameter int DW       = RAM_DW,
  parameter int HOLD_CYC = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          ram_cs,
  output logic          ram_we,
  output logic          ram_re,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  input  logic [DW-1:0] ram_q
);

  state_t            state;
  op_t               op;
  logic              last_gnt;
  logic              cur_port;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]        gnt;

  rr_arb2 u_arb (
    .req      ({req1, req0}),
    .last_gnt (last_gnt),
    .enable   (state == IDLE),
    .gnt      (gnt)
  );

  // Access sequencer: every RAM-facing signal and ack is a flop so strobes cannot glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op       <= OP_RD;
      last_gnt <= 1'b1;
      cur_port <= 1'b0;
      hold_cnt <= '0;
      ram_cs   <= 1'b0;
      ram_we   <= 1'b0;
      ram_re   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      rdata    <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt != 2'b00) begin
            cur_port <= gnt[1];
            last_gnt <= gnt[1];
            op       <= gnt[1] ? op_t'(wr1) : op_t'(wr0);
            ram_addr <= gnt[1] ? addr1 : addr0;
            ram_data <= gnt[1] ? wdata1 : wdata0;
            ram_cs   <= 1'b1;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          // Address/data have been stable for a full cycle; raise the strobe now.
          ram_we   <= (op == OP_WR);
          ram_re   <= (op == OP_RD);
          hold_cnt <= hold_load(HOLD_CYC);
          state    <= STROBE;
        end
        STROBE: begin
          if (hold_cnt == '0) begin
            ram_we <= 1'b0;
            ram_re <= 1'b0;
            // Capture on entry to DONE so rdata is valid in the same cycle as ack.
            if (op == OP_RD) begin
              rdata <= ram_q;
            end
            ack0  <= ~cur_port;
            ack1  <= cur_port;
            state <= DONE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        DONE: begin
          ram_cs <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural edge-strobed RAM.
`timescale 1ns/1ps
module tb_ram_access_ctrl;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, busy, ram_cs, ram_we, ram_re;
  logic [DW-1:0] rdata, ram_data, ram_q;
  logic [AW-1:0] ram_addr;

  // Second instance built with HOLD_CYC=3
  logic          h_req0 = 1'b0, h_wr0 = 1'b0, h_req1 = 1'b0, h_wr1 = 1'b0;
  logic [AW-1:0] h_addr0 = '0, h_addr1 = '0;
  logic [DW-1:0] h_wdata0 = '0, h_wdata1 = '0;
  logic          h_ack0, h_ack1, h_busy, h_cs, h_we, h_re;
  logic [DW-1:0] h_rdata, h_data, h_q;
  logic [AW-1:0] h_addr;

  int n_pass = 0;
  int n_total = 0;

  ram_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .busy(busy), .ram_cs(ram_cs), .ram_we(ram_we), .ram_re(ram_re),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q)
  );

  ram_access_ctrl #(.HOLD_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0(h_req0), .wr0(h_wr0), .addr0(h_addr0), .wdata0(h_wdata0), .ack0(h_ack0),
    .req1(h_req1), .wr1(h_wr1), .addr1(h_addr1), .wdata1(h_wdata1), .ack1(h_ack1),
    .rdata(h_rdata), .busy(h_busy), .ram_cs(h_cs), .ram_we(h_we), .ram_re(h_re),
    .ram_addr(h_addr), .ram_data(h_data), .ram_q(h_q)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: writes latch on rising we, reads on rising re, both qualified by cs
  logic [DW-1:0] mem [0:255];
  int            we_rises = 0, re_rises = 0, ack0_cnt = 0, ack1_cnt = 0, h_we_rises = 0;
  logic [AW-1:0] we_addr = '0, re_addr = '0;
  logic [DW-1:0] we_data = '0;

  always @(posedge ram_we) if (ram_cs) begin
    mem[ram_addr] = ram_data;
    we_rises++;
    we_addr = ram_addr;
    we_data = ram_data;
  end

  always @(posedge ram_re) if (ram_cs) begin
    ram_q = mem[ram_addr];
    re_rises++;
    re_addr = ram_addr;
  end

  always @(posedge ack0) ack0_cnt++;
  always @(posedge ack1) ack1_cnt++;

  always @(posedge h_re) if (h_cs) h_q = {8'h5A, h_addr};
  always @(posedge h_we) h_we_rises++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit port, input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if ((port ? ack1 : ack0) === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_total++; if (ram_cs !== 1'b0) $display("FAIL reset_cs: got %b want 0", ram_cs); else n_pass++;
    n_total++; if ({ram_we, ram_re} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {ram_we, ram_re}); else n_pass++;
    n_total++; if ({ack0, ack1, busy} !== 3'b000) $display("FAIL reset_ack_busy: got %b want 000", {ack0, ack1, busy}); else n_pass++;
    n_total++; if (ram_addr !== 8'h00) $display("FAIL reset_addr: got %h want 00", ram_addr); else n_pass++;
    n_total++; if (ram_data !== 16'h0000) $display("FAIL reset_data: got %h want 0000", ram_data); else n_pass++;
    n_total++; if (rdata !== 16'h0000) $display("FAIL reset_rdata: got %h want 0000", rdata); else n_pass++;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single_write();
    int c;
    int w0;
    w0 = we_rises;
    addr0 = 8'h12; wdata0 = 16'hBEEF; wr0 = 1'b1; req0 = 1'b1;
    wait_ack(1'b0, 20, c);
    req0 = 1'b0;
    n_total++; if (c !== 3) $display("FAIL wr_latency: got %0d want 3", c); else n_pass++;
    n_total++; if (we_rises - w0 !== 1) $display("FAIL wr_we_rises: got %0d want 1", we_rises - w0); else n_pass++;
    n_total++; if (we_addr !== 8'h12) $display("FAIL wr_addr_at_edge: got %h want 12", we_addr); else n_pass++;
    n_total++; if (we_data !== 16'hBEEF) $display("FAIL wr_data_at_edge: got %h want beef", we_data); else n_pass++;
    n_total++; if ({ram_cs, ram_we, ack1} !== 3'b100) $display("FAIL wr_done_state: got %b want 100", {ram_cs, ram_we, ack1}); else n_pass++;
    n_total++; if (rdata !== 16'h0000) $display("FAIL wr_rdata_unchanged: got %h want 0000", rdata); else n_pass++;
    tick();
    n_total++; if ({ack0, busy, ram_cs} !== 3'b000) $display("FAIL wr_back_idle: got %b want 000", {ack0, busy, ram_cs}); else n_pass++;
    n_total++; if (ram_addr !== 8'h12) $display("FAIL wr_addr_hold: got %h want 12", ram_addr); else n_pass++;
  endtask

  task automatic test_read_back();
    int c;
    int r0;
    r0 = re_rises;
    addr1 = 8'h12; wr1 = 1'b0; req1 = 1'b1;
    wait_ack(1'b1, 20, c);
    req1 = 1'b0;
    n_total++; if (c !== 3) $display("FAIL rd_latency: got %0d want 3", c); else n_pass++;
    n_total++; if (re_rises - r0 !== 1) $display("FAIL rd_re_rises: got %0d want 1", re_rises - r0); else n_pass++;
    n_total++; if (re_addr !== 8'h12) $display("FAIL rd_addr_at_edge: got %h want 12", re_addr); else n_pass++;
    n_total++; if (rdata !== 16'hBEEF) $display("FAIL rd_rdata_ack: got %h want beef", rdata); else n_pass++;
    n_total++; if (ack0 !== 1'b0) $display("FAIL rd_wrong_ack: got %b want 0", ack0); else n_pass++;
    repeat (3) tick();
    n_total++; if (rdata !== 16'hBEEF) $display("FAIL rd_rdata_hold: got %h want beef", rdata); else n_pass++;
    n_total++; if (ack1 !== 1'b0) $display("FAIL rd_ack_pulse: got %b want 0", ack1); else n_pass++;
  endtask

  task automatic test_contention();
    int order [4];
    int at [4];
    int k;
    int cyc;
    for (int i = 0; i < 4; i++) begin order[i] = -1; at[i] = -1; end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    addr0 = 8'h20; wdata0 = 16'h1111; wr0 = 1'b1;
    addr1 = 8'h21; wdata1 = 16'h2222; wr1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    k = 0; cyc = 0;
    while (k < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (ack0 === 1'b1) begin order[k] = 0; at[k] = cyc; k++; end
      else if (ack1 === 1'b1) begin order[k] = 1; at[k] = cyc; k++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_total++; if (k !== 4) $display("FAIL arb_ack_count: got %0d want 4", k); else n_pass++;
    n_total++; if (order[0] !== 0) $display("FAIL arb_grant0: got %0d want 0", order[0]); else n_pass++;
    n_total++; if (order[1] !== 1) $display("FAIL arb_grant1: got %0d want 1", order[1]); else n_pass++;
    n_total++; if (order[2] !== 0) $display("FAIL arb_grant2: got %0d want 0", order[2]); else n_pass++;
    n_total++; if (order[3] !== 1) $display("FAIL arb_grant3: got %0d want 1", order[3]); else n_pass++;
    n_total++; if (at[0] !== 3 || at[3] !== 15) $display("FAIL arb_timing: got %0d,%0d want 3,15", at[0], at[3]); else n_pass++;
    n_total++; if (mem[8'h20] !== 16'h1111) $display("FAIL arb_mem20: got %h want 1111", mem[8'h20]); else n_pass++;
    n_total++; if (mem[8'h21] !== 16'h2222) $display("FAIL arb_mem21: got %h want 2222", mem[8'h21]); else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_strobe();
    int a0;
    int a1;
    int first;
    int c;
    addr0 = 8'h30; wdata0 = 16'h5555; wr0 = 1'b1; req0 = 1'b1;
    tick();
    tick();
    n_total++; if (ram_we !== 1'b1) $display("FAIL rst_pre_strobe: got %b want 1", ram_we); else n_pass++;
    a0 = ack0_cnt; a1 = ack1_cnt;
    #1 rst_n = 1'b0;
    #1;
    n_total++; if ({ram_we, ram_cs} !== 2'b00) $display("FAIL rst_async_strobe: got %b want 00", {ram_we, ram_cs}); else n_pass++;
    n_total++; if ({ack0, ack1, busy} !== 3'b000) $display("FAIL rst_async_ack: got %b want 000", {ack0, ack1, busy}); else n_pass++;
    req0 = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_total++; if (ack0_cnt !== a0 || ack1_cnt !== a1) $display("FAIL rst_no_ack: got %0d,%0d want %0d,%0d", ack0_cnt, ack1_cnt, a0, a1); else n_pass++;
    addr0 = 8'h12; wr0 = 1'b0; addr1 = 8'h12; wr1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    first = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack0 === 1'b1) begin first = 0; break; end
      if (ack1 === 1'b1) begin first = 1; break; end
    end
    n_total++; if (first !== 0) $display("FAIL rst_first_winner: got %0d want 0", first); else n_pass++;
    req0 = 1'b0;
    wait_ack(1'b1, 20, c);
    req1 = 1'b0;
    n_total++; if (c !== 4) $display("FAIL rst_second_wait: got %0d want 4", c); else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    int c;
    addr0 = 8'h12; wdata0 = 16'hCAFE; wr0 = 1'b1; req0 = 1'b1;
    wait_ack(1'b0, 20, c);
    n_total++; if (c !== 3) $display("FAIL b2b_first_latency: got %0d want 3", c); else n_pass++;
    addr0 = 8'h13; wdata0 = 16'h1313;
    tick();
    n_total++; if ({busy, ram_cs} !== 2'b00 || ram_addr !== 8'h12) $display("FAIL b2b_idle_gap: got %b/%h want 00/12", {busy, ram_cs}, ram_addr); else n_pass++;
    tick();
    n_total++; if ({busy, ram_cs, ram_we} !== 3'b110) $display("FAIL b2b_setup_start: got %b want 110", {busy, ram_cs, ram_we}); else n_pass++;
    n_total++; if (ram_addr !== 8'h13 || ram_data !== 16'h1313) $display("FAIL b2b_setup_addr: got %h/%h want 13/1313", ram_addr, ram_data); else n_pass++;
    wait_ack(1'b0, 20, c);
    req0 = 1'b0;
    n_total++; if (c !== 2) $display("FAIL b2b_second_ack: got %0d want 2", c); else n_pass++;
    n_total++; if (mem[8'h13] !== 16'h1313 || mem[8'h12] !== 16'hCAFE) $display("FAIL b2b_mem: got %h/%h want 1313/cafe", mem[8'h13], mem[8'h12]); else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_hold3();
    int c;
    int hi;
    int w0;
    w0 = h_we_rises;
    h_addr0 = 8'h44; h_wr0 = 1'b0; h_req0 = 1'b1;
    c = -1; hi = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (h_re === 1'b1) hi++;
      if (h_ack0 === 1'b1) begin c = i; break; end
    end
    h_req0 = 1'b0;
    n_total++; if (hi !== 3) $display("FAIL h3_re_width: got %0d want 3", hi); else n_pass++;
    n_total++; if (c !== 5) $display("FAIL h3_latency: got %0d want 5", c); else n_pass++;
    n_total++; if (h_rdata !== 16'h5A44) $display("FAIL h3_rdata: got %h want 5a44", h_rdata); else n_pass++;
    n_total++; if (h_ack1 !== 1'b0 || h_we_rises !== w0 || h_data !== 16'h0000) $display("FAIL h3_side: got %b/%0d/%h want 0/%0d/0000", h_ack1, h_we_rises, h_data, w0); else n_pass++;
    tick();
    n_total++; if (h_busy !== 1'b0) $display("FAIL h3_busy: got %b want 0", h_busy); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_back();
    test_contention();
    test_reset_mid_strobe();
    test_back_to_back();
    test_hold3();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Two-port arbiter and sequencer for the 256x16 edge-strobed data RAM, which latches writes on the rising edge of we and reads on the rising edge of re, both qualified by cs.
- Accepts word requests from two masters (port 0 = CPU data path, port 1 = DMA/IO) and grants them round-robin.
- Generates glitch-free, registered cs/we/re strobes with address and data set up one full clock before the strobe edge.
- Returns read data and a one-cycle ack per request.

Parameters:
- AW, 8, RAM address width
- DW, 16, RAM data width
- HOLD_CYC, 1, cycles the we/re strobe is held high (legal range 1..15)

Ports:
- clk  in  1  system clock, all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  port 0 request; held high until ack0
- wr0  in  1  port 0 type: 1 = write, 0 = read; stable while req0
- addr0  in  AW  port 0 word address; stable while req0
- wdata0  in  DW  port 0 write data; stable while req0
- ack0  out  1  port 0 completion pulse, one cycle
- req1, wr1, addr1, wdata1, ack1: same as port 0, for port 1
- rdata  out  DW  read data of the most recent completed read (either port)
- busy  out  1  high whenever the FSM is not IDLE
- ram_cs  out  1  RAM chip select
- ram_we  out  1  RAM write strobe (rising edge active)
- ram_re  out  1  RAM read strobe (rising edge active)
- ram_addr  out  AW  RAM address
- ram_data  out  DW  RAM write data
- ram_q  in  DW  RAM read data

Behaviour:
- All outputs are registered. Reset (async, rst_n low) forces:
  - FSM to IDLE
  - ram_cs, ram_we, ram_re, ack0, ack1, busy to 0
  - ram_addr, ram_data, rdata to 0
  - round-robin pointer last_gnt to 1, so port 0 wins the first contention
- Reset mid-access: strobes drop immediately; no ack is issued; the access is abandoned. A falling we/re edge has no RAM effect.
- FSM states: IDLE -> SETUP -> STROBE -> DONE -> IDLE.
- IDLE:
  - If any req is high, select a grantee. Only one requesting: that port. Both requesting: the port != last_gnt.
  - Latch the grantee's addr/wdata/wr into ram_addr/ram_data/op, update last_gnt, go to SETUP.
- SETUP (1 cycle): ram_cs=1, ram_we=ram_re=0, address and data stable.
- STROBE (HOLD_CYC cycles, counted by hold_cnt): ram_cs=1; ram_we=1 if op is write, else ram_re=1. The rising strobe edge coincides with SETUP->STROBE.
- DONE (1 cycle):
  - Strobes return to 0; ram_cs stays 1.
  - For a read, rdata <= ram_q. For a write, rdata is unchanged.
  - Pulse ack of the grantee. ram_cs deasserts on the transition to IDLE.
- Latency: req sampled in IDLE at cycle N -> ack at cycle N+2+HOLD_CYC (N+3 at default). rdata is valid in the same cycle as ack and holds until the next read completes.
- Throughput: one access per HOLD_CYC+3 cycles. No access is granted in the cycle the FSM returns to IDLE from DONE, because IDLE decides on the next edge.
- If a master holds req high after its ack, that is a new request.
- A req dropped before ack is a protocol violation. The controller still completes the latched access and pulses ack.
- Requests arriving while busy wait. A waiting port is guaranteed a grant within one access of the competing port (no starvation).
- ram_addr and ram_data hold their last values in IDLE. They change only on grant.
- wr/addr/wdata are ignored for non-granted ports and outside IDLE sampling.

Decomposition:
- Package mcu_ram_pkg: AW/DW defaults, state enum (IDLE, SETUP, STROBE, DONE), op encoding (OP_RD=0, OP_WR=1).
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], last_gnt, enable.
  - Output: one-hot gnt[1:0], combinational.
  - last_gnt register stays in the parent.

Test Plan:
- Reset then single write: req0 with wr0=1, addr0=0x12, wdata0=0xBEEF. Required: ram_we rises exactly once while ram_addr=0x12 and ram_data=0xBEEF, ack0 pulses 3 cycles after the sampled request, and busy returns to 0.
- Read-back: req1 with wr1=0, addr1=0x12, model RAM returns 0xBEEF. Required: ram_re rises once, ack1 pulses, rdata=0xBEEF in the ack cycle and holds afterwards.
- Contention: req0 and req1 raised in the same cycle after reset. Required: port 0 is served first, then port 1. With both held continuously, grants alternate 0,1,0,1 and no port waits more than one access.
- HOLD_CYC=3 build: single read. Required: ram_re is high for exactly 3 cycles and ack arrives 5 cycles after the sampled request.
- Async reset asserted during STROBE of a write. Required: ram_we, ram_cs, ack0 and ack1 go to 0 without waiting for clk, no ack is issued, and after release port 0 wins the first contention.
- Back-to-back: req0 held high through ack0 with addr0 changed to 0x13. Required: a second access to 0x13 starts, and SETUP begins 2 cycles after the first ack.
